// File: rtl/pc_seq_pkg.sv
//------------------------------------------------------------------------------
// Module  : pc_seq_pkg
// Brief   : Shared state type and constants for the program-counter sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pc_seq_pkg;

  // Sequencer states; the encoding is fixed so it reads the same in any dump.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  // Byte distance between consecutive sequential fetches.
  localparam int unsigned PC_INC = 4;

  // True when an address is not aligned to a 4-byte instruction boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
//------------------------------------------------------------------------------
// Module  : pc_next_mux
// Brief   : Combinational next-PC selection and misalign detection.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int unsigned       WIDTH        = 64,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(64'h0),
  parameter logic [WIDTH-1:0]  TRAP_VECTOR  = WIDTH'(64'h100)
) (
  input  state_e             state_i,
  input  logic [WIDTH-1:0]   pc_i,
  input  logic               trap_i,
  input  logic               branch_taken_i,
  input  logic [WIDTH-1:0]   branch_target_i,
  input  logic               handshake_i,
  output logic [WIDTH-1:0]   pc_d_o,
  output logic               misalign_d_o
);

  // Redirects outrank the sequential increment; a misaligned branch is
  // diverted to the trap vector and flagged. In HALT only a trap moves the PC.
  always_comb begin
    pc_d_o       = pc_i;
    misalign_d_o = 1'b0;
    case (state_i)
      BOOT: begin
        pc_d_o = RESET_VECTOR;
      end
      FETCH: begin
        if (trap_i) begin
          pc_d_o = TRAP_VECTOR;
        end else if (branch_taken_i && is_misaligned(branch_target_i[1:0])) begin
          pc_d_o       = TRAP_VECTOR;
          misalign_d_o = 1'b1;
        end else if (branch_taken_i) begin
          pc_d_o = branch_target_i;
        end else if (handshake_i) begin
          pc_d_o = pc_i + WIDTH'(PC_INC);
        end
      end
      HALT: begin
        if (trap_i) begin
          pc_d_o = TRAP_VECTOR;
        end
      end
      default: begin
        pc_d_o = RESET_VECTOR;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// Module  : pc_sequencer
// Brief   : Instruction-fetch PC sequencer with BOOT/FETCH/HALT control,
//           redirect handling and a completed-fetch counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       WIDTH        = 64,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(64'h0),
  parameter logic [WIDTH-1:0]  TRAP_VECTOR  = WIDTH'(64'h100)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [WIDTH-1:0]   branch_target,
  input  logic               trap,
  input  logic               halt_req,
  input  logic               resume,
  output logic [WIDTH-1:0]   pc_out,
  output logic               imem_req,
  output logic [31:0]        fetch_count,
  output logic               halted,
  output logic               misalign
);

  state_e             state_q;
  logic [WIDTH-1:0]   pc_q;
  logic [WIDTH-1:0]   pc_d;
  logic [31:0]        count_q;
  logic               misalign_q;
  logic               misalign_d;
  logic               w_handshake;

  assign imem_req    = (state_q == FETCH) && !stall;
  assign w_handshake = imem_req && imem_ready;

  pc_next_mux #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (RESET_VECTOR),
    .TRAP_VECTOR  (TRAP_VECTOR)
  ) u_pc_next_mux (
    .state_i         (state_q),
    .pc_i            (pc_q),
    .trap_i          (trap),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .handshake_i     (w_handshake),
    .pc_d_o          (pc_d),
    .misalign_d_o    (misalign_d)
  );

  // Control FSM plus PC, fetch counter and misalign pulse registers. A halt
  // request only lands on a completed handshake, even if the PC is redirected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      count_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      if (w_handshake) begin
        count_q <= count_q + 32'd1;
      end
      case (state_q)
        BOOT:    state_q <= FETCH;
        FETCH:   if (w_handshake && halt_req) state_q <= HALT;
        HALT:    if (trap || resume) state_q <= FETCH;
        default: state_q <= BOOT;
      endcase
    end
  end

  assign pc_out      = pc_q;
  assign fetch_count = count_q;
  assign halted      = (state_q == HALT);
  assign misalign    = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_pc_sequencer
// Brief   : Self-checking bench for pc_sequencer (vector table, hand-written
//           reset sequence, randomized run against a reference model).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  localparam logic [63:0] TRAPV = 64'h100;

  logic        clk;
  logic        reset_n;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        trap;
  logic        halt_req;
  logic        resume;
  logic [63:0] pc_out;
  logic        imem_req;
  logic [31:0] fetch_count;
  logic        halted;
  logic        misalign;

  int n_total = 0;
  int n_pass  = 0;

  pc_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .trap          (trap),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc_out        (pc_out),
    .imem_req      (imem_req),
    .fetch_count   (fetch_count),
    .halted        (halted),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        br;
    logic [63:0] tgt;
    logic        trap;
    logic        halt;
    logic        resume;
    logic        e_req;
    logic [63:0] e_pc;
    logic [31:0] e_cnt;
    logic        e_halted;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic rdy, input logic br,
                              input logic [63:0] tgt, input logic tr,
                              input logic hl, input logic rs, input logic e_req,
                              input logic [63:0] e_pc, input logic [31:0] e_cnt,
                              input logic e_h, input logic e_m);
    vec_t v;
    v.stall = st; v.ready = rdy; v.br = br; v.tgt = tgt; v.trap = tr;
    v.halt = hl; v.resume = rs; v.e_req = e_req; v.e_pc = e_pc;
    v.e_cnt = e_cnt; v.e_halted = e_h; v.e_mis = e_m;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic clear_inputs();
    imem_ready = 0; stall = 0; branch_taken = 0; branch_target = '0;
    trap = 0; halt_req = 0; resume = 0;
  endtask

  // Reset asserted just after a rising edge and released after the next one;
  // the edge following release is the BOOT cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  // Reference model: mode 0 = boot, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;

  function automatic logic model_req();
    return (m_mode == 1) && !stall;
  endfunction

  task automatic model_edge();
    logic accepted;
    accepted = model_req() && imem_ready;
    m_mis = 0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (accepted) m_cnt = m_cnt + 1;
      if (trap)                                    m_pc = TRAPV;
      else if (branch_taken && (branch_target % 4 != 0)) begin m_pc = TRAPV; m_mis = 1; end
      else if (branch_taken)                       m_pc = branch_target;
      else if (accepted)                           m_pc = m_pc + 4;
      if (accepted && halt_req) m_mode = 2;
    end else begin
      if (trap) begin m_pc = TRAPV; m_mode = 1; end
      else if (resume) m_mode = 1;
    end
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;

    //                st rdy br tgt                      tr hl rs req pc                       cnt h  m
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 0, 0, 0, 64'h0,                    0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 0, 0, 1, 64'h4,                    1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 0, 0, 1, 64'h8,                    2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 0, 0, 1, 64'hC,                    3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 0, 0, 1, 64'h10,                   4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0,                     0, 0, 0, 1, 64'h10,                   4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0,                     0, 0, 0, 1, 64'h10,                   4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0,                     0, 0, 0, 1, 64'h10,                   4, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 0, 0, 1, 64'h14,                   5, 0, 0));
    tbl.push_back(mk(1, 1, 1, 64'h40,                    0, 0, 0, 0, 64'h40,                   5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 64'h42,                    0, 0, 0, 1, 64'h100,                  5, 0, 1));
    tbl.push_back(mk(0, 0, 0, 64'h0,                     0, 0, 0, 1, 64'h100,                  5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 64'h42,                    1, 0, 0, 1, 64'h100,                  5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 64'h8,                     0, 0, 0, 1, 64'h8,                    5, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 1, 0, 1, 64'hC,                    6, 1, 0));
    tbl.push_back(mk(0, 1, 1, 64'h40,                    0, 0, 0, 0, 64'hC,                    6, 1, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0,                     0, 1, 1, 0, 64'hC,                    6, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 0, 0, 1, 64'h10,                   7, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 1, 0, 1, 64'h14,                   8, 1, 0));
    tbl.push_back(mk(0, 0, 0, 64'h0,                     1, 0, 0, 0, 64'h100,                  8, 0, 0));
    tbl.push_back(mk(1, 1, 0, 64'h0,                     0, 0, 0, 0, 64'h100,                  8, 0, 0));
    tbl.push_back(mk(0, 1, 1, 64'h20,                    0, 0, 0, 1, 64'h20,                   9, 0, 0));
    tbl.push_back(mk(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC,   0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC,  9, 0, 0));
    tbl.push_back(mk(0, 1, 0, 64'h0,                     0, 0, 0, 1, 64'h0,                   10, 0, 0));

    // Reset state, then release so the first table row runs the BOOT edge.
    @(posedge clk); #1;
    chk("reset pc_out", pc_out, 64'h0);
    chk("reset fetch_count", 64'(fetch_count), 64'h0);
    chk("reset halted", 64'(halted), 64'h0);
    chk("reset misalign", 64'(misalign), 64'h0);
    chk("reset imem_req", 64'(imem_req), 64'h0);
    reset_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      stall = tbl[i].stall; imem_ready = tbl[i].ready; branch_taken = tbl[i].br;
      branch_target = tbl[i].tgt; trap = tbl[i].trap; halt_req = tbl[i].halt;
      resume = tbl[i].resume;
      #1 chk($sformatf("row%0d imem_req", i), 64'(imem_req), 64'(tbl[i].e_req));
      @(posedge clk); #1;
      chk($sformatf("row%0d pc_out", i), pc_out, tbl[i].e_pc);
      chk($sformatf("row%0d fetch_count", i), 64'(fetch_count), 64'(tbl[i].e_cnt));
      chk($sformatf("row%0d halted", i), 64'(halted), 64'(tbl[i].e_halted));
      chk($sformatf("row%0d misalign", i), 64'(misalign), 64'(tbl[i].e_mis));
    end

    // Asynchronous reset in the middle of an active handshake at pc=0x20.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      imem_ready = 1;
    end
    @(posedge clk); #1;
    chk("pre-reset pc_out", pc_out, 64'h20);
    chk("pre-reset fetch_count", 64'(fetch_count), 64'd8);
    @(negedge clk);
    imem_ready = 1;
    #2 reset_n = 0;
    #1;
    chk("async reset pc_out", pc_out, 64'h0);
    chk("async reset fetch_count", 64'(fetch_count), 64'h0);
    chk("async reset imem_req", 64'(imem_req), 64'h0);
    chk("async reset misalign", 64'(misalign), 64'h0);
    @(posedge clk); #1;
    chk("held reset pc_out", pc_out, 64'h0);
    @(negedge clk);
    reset_n = 1;
    #1 chk("boot imem_req", 64'(imem_req), 64'h0);
    @(posedge clk); #1;
    chk("after boot pc_out", pc_out, 64'h0);
    chk("after boot fetch_count", 64'(fetch_count), 64'h0);
    chk("after boot imem_req", 64'(imem_req), 64'h1);
    @(posedge clk); #1;
    chk("first fetch pc_out", pc_out, 64'h4);
    chk("first fetch fetch_count", 64'(fetch_count), 64'd1);

    // Randomized run against the reference model.
    do_reset();
    m_mode = 0; m_pc = 64'h0; m_cnt = 0; m_mis = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      imem_ready   = ($urandom_range(0, 9) < 6);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      branch_target = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
      trap         = ($urandom_range(0, 29) == 0);
      halt_req     = ($urandom_range(0, 19) == 0);
      resume       = ($urandom_range(0, 4) == 0);
      #1 chk($sformatf("rand%0d imem_req", i), 64'(imem_req), 64'(model_req()));
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("rand%0d pc_out", i), pc_out, m_pc);
      chk($sformatf("rand%0d fetch_count", i), 64'(fetch_count), 64'(m_cnt));
      chk($sformatf("rand%0d halted", i), 64'(halted), 64'(m_mode == 2));
      chk($sformatf("rand%0d misalign", i), 64'(misalign), 64'(m_mis));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
